// File: rtl/ysyx_22050612_mem_pkg.sv
// ysyx_22050612_mem_pkg: shared widths and FSM state type for the data-memory responder.
package ysyx_22050612_mem_pkg;
  localparam int WORD_W = 64;
  localparam int BYTE_LANES = 8;
  localparam int MASK_W = BYTE_LANES;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
endpackage

// File: rtl/ysyx_22050612_mem_bytewrite_ram.sv
// ysyx_22050612_mem_bytewrite_ram: 64-bit word array with per-byte write enables and a registered read port.
module ysyx_22050612_mem_bytewrite_ram
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [MASK_W-1:0]     wmask_i,
  output logic [WORD_W-1:0]     rdata_o
);
  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [WORD_W-1:0] rdata_q;
  // Read register only moves on a read accept, so it doubles as the response holding register.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[addr_i];
    for (int i = 0; i < MASK_W; i++)
      if (we_i && wmask_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/ysyx_22050612_mem_responder.sv
// ysyx_22050612_mem_responder: data-memory responder with programmable response latency.
// Define YSYX_22050612_MEMRSP_RANGE_CHECK_EN to flag out-of-window accesses instead of aliasing them.
module ysyx_22050612_mem_responder
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [WORD_W-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [WORD_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  input  logic [MASK_W-1:0] req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic accept, addr_err, unused_bits;
  logic [WORD_W-1:0] offset, ram_rdata;
  logic [DEPTH_LOG2-1:0] index;
  assign offset = req_addr_i - BASE_ADDR;
  assign index = offset[DEPTH_LOG2+2:3];
`ifdef YSYX_22050612_MEMRSP_RANGE_CHECK_EN
  // Addresses below the base wrap to a huge offset, so one upper-bit test covers both ends.
  assign addr_err = |offset[WORD_W-1:DEPTH_LOG2+3];
  assign unused_bits = ^offset[2:0];
`else
  assign addr_err = 1'b0;
  assign unused_bits = ^{offset[WORD_W-1:DEPTH_LOG2+3], offset[2:0]};
`endif
  assign req_ready_o = (state_q == IDLE) || (state_q == RESP && rsp_ready_i);
  assign accept = req_valid_i && req_ready_o;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_err_o = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !wr_q && !err_q) ? ram_rdata : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    err_d = err_q;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? RESP : BUSY;
    end
    if (state_q == RESP && rsp_ready_i) state_d = IDLE;
    if (accept) begin
      cnt_d = LAT_C;
      wr_d = req_wen_i;
      err_d = addr_err;
      state_d = (LATENCY > 0) ? BUSY : RESP;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      err_q <= err_d;
    end
  end
  ysyx_22050612_mem_bytewrite_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (accept && req_wen_i && !addr_err),
    .re_i    (accept && !req_wen_i),
    .addr_i  (index),
    .wdata_i (req_wdata_i),
    .wmask_i (req_wmask_i),
    .rdata_o (ram_rdata)
  );
endmodule
